multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the RV32I multicycle core. Sits directly upstream of the datapath and drives all of its
//  write strobes and mux/ALU selects. Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction from the IR fields.
//  Supports R-type ALU, I-type ALU, LW and SW. Any other encoding traps. Counts retired instructions.
// PARAMETERS
//  TRAP_ON_ILLEGAL  1   1: illegal encoding enters TRAP and holds there; 0: illegal treated as NOP (DECODE->FETCH)
//  INSTRET_W        32  width of retired-instruction counter
// PORTS
//  clk            in   1          rising-edge clock, single domain
//  rst            in   1          synchronous, active-high reset
//  opcode         in   7          IR[6:0]; stable from DECODE until next FETCH
//  funct3         in   3          IR[14:12]
//  funct7_5       in   1          IR[30]
//  pc_write       out  1          load PC with PC+4
//  ir_write       out  1          latch memory read data into IR
//  mem_write      out  1          memory write strobe
//  mdr_write      out  1          latch memory read data into MDR
//  reg_write      out  1          register-file write strobe (rd)
//  imm_ctrl       out  3          000 I-type, 001 S-type; other codes reserved
//  alu_ctrl       out  4          0000 add,0001 sub,0010 and,0011 or,0100 xor,0101 sll,0110 srl,0111 sra,1000 slt,1001 sltu
//  alu_in2_ctrl   out  1          0 rs2, 1 immediate
//  addrsrc_ctrl   out  1          memory address: 0 PC, 1 ALU result
//  regwrite_ctrl  out  1          rd data: 0 ALU result, 1 MDR
//  illegal        out  1          high while in TRAP
//  instret        out  INSTRET_W  retired-instruction count
// BEHAVIOUR
//  States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, TRAP.
//  Reset: while rst=1, every output is 0 (strobes, selects, illegal, instret). State<=FETCH.
//   The first cycle after rst falls is FETCH.
//  Outputs are a Moore decode of the state register plus the IR fields. Unlisted outputs are 0 in each state.
//  FETCH: pc_write=1, ir_write=1, addrsrc=0. Next state: DECODE.
//  DECODE: all strobes 0; the register file reads rs1/rs2. Next state by opcode:
//   0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 with f3=010 -> MEM_ADDR; 0100011 with f3=010 -> MEM_ADDR.
//   Any other encoding -> TRAP (or FETCH if TRAP_ON_ILLEGAL=0).
//  R-type legality: funct7_5=1 is allowed only for f3=000 (sub) and f3=101 (sra). Otherwise the instruction is illegal.
//  I-type legality: f3=001 requires funct7_5=0. For f3=101, funct7_5 selects srl/sra. For other f3, funct7_5 is ignored (immediate bit).
//  EXEC_R: alu_in2=0, alu_ctrl=decode(f3,f7_5). Next state: ALU_WB.
//  EXEC_I: alu_in2=1, imm_ctrl=000, alu_ctrl=decode(f3,f7_5 only for 101). Next state: ALU_WB.
//  ALU_WB: reg_write=1, regwrite_ctrl=0. ALU selects are held identical to the EXEC state. Next state: FETCH.
//  MEM_ADDR: alu_ctrl=add, alu_in2=1, imm_ctrl=000 (load) or 001 (store). Next state: MEM_RD (load) or MEM_WR (store).
//  MEM_RD: addrsrc=1, mdr_write=1, with MEM_ADDR selects held. Next state: MEM_WB.
//  MEM_WB: reg_write=1, regwrite_ctrl=1. Next state: FETCH.
//  MEM_WR: addrsrc=1, mem_write=1, with MEM_ADDR selects held. Next state: FETCH.
//  Latency in cycles: R/I = 4, LW = 5, SW = 4. FETCH always lasts exactly 1 cycle; there is no memory wait.
//  TRAP: all strobes 0, illegal=1. Only rst exits TRAP. instret is frozen in TRAP.
//  instret: increments by 1 on the clock edge leaving ALU_WB, MEM_WB or MEM_WR. Wraps modulo 2^INSTRET_W.
//   An illegal instruction in NOP mode (TRAP_ON_ILLEGAL=0) does not count.
//  Reset mid-instruction: the next edge aborts the instruction with no partial strobes. instret clears to 0.
//  Strobes are one-hot per cycle: pc_write and ir_write share FETCH. No other two write strobes are ever high together.
// STRUCTURE
//  Shared include rv32_ctrl_defs.vh holds:
//   opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE), ALU codes (ALU_ADD..ALU_SLTU), IMM_I/IMM_S, state encodings.
//  Sub-module alu_decoder (combinational): {is_itype, funct3, funct7_5} -> {alu_ctrl, legal}.
//   The top level holds the state register, next-state logic, output decode and the instret counter.
// TESTING
//  Drive a memory model with the datapath, or stub the IR fields directly. Check per-cycle strobes against the state table.
//  1. rst high 2 cycles, then low -> all outputs 0 during reset; cycle 1 after reset: pc_write=ir_write=1.
//  2. IR=0x00508193 (addi x3,x1,5), x1=0x80 -> ALU_WB at cycle 4: reg_write=1, alu_ctrl=0000, alu_in2=1.
//     x3=133, instret=1.
//  3. IR=0x4030D193 (srai x3,x1,3), x1=0x80 -> alu_ctrl=0111; x3=16. IR=0x40208133 (sub) -> alu_ctrl=0001, alu_in2=0.
//  4. SW then LW to the same address (0x0030A223 sw x3,4(x1), then 0x0040A203 lw x4,4(x1)).
//     Expected: mem_write for exactly 1 cycle with addrsrc=1 and imm_ctrl=001.
//     Then 5 cycles for the load, with regwrite_ctrl=1 and x4=x3.
//  5. IR=0x0000006F (jal) -> illegal=1 after DECODE; no strobes for 20 cycles; instret frozen.
//     Same stimulus with TRAP_ON_ILLEGAL=0 -> FETCH follows DECODE and instret is unchanged.
//  6. Assert rst in MEM_RD -> no reg_write issued; FETCH is the first state after reset; instret=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared constants for the RV32I multicycle control path: opcode values,
// ALU operation codes, immediate-format selects, FSM state encodings, and the
// packed bundle of control outputs driven toward the datapath.
// No ports (package).
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

   // Major opcodes handled by the core
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   // funct3 of the only supported load/store width (word)
   localparam logic [2:0] F3_WORD  = 3'b010;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   // Immediate generator format selects
   localparam logic [2:0] IMM_I    = 3'b000;
   localparam logic [2:0] IMM_S    = 3'b001;

   // FSM state encodings
   localparam logic [3:0] ST_FETCH    = 4'd0;
   localparam logic [3:0] ST_DECODE   = 4'd1;
   localparam logic [3:0] ST_EXEC_R   = 4'd2;
   localparam logic [3:0] ST_EXEC_I   = 4'd3;
   localparam logic [3:0] ST_MEM_ADDR = 4'd4;
   localparam logic [3:0] ST_MEM_RD   = 4'd5;
   localparam logic [3:0] ST_MEM_WB   = 4'd6;
   localparam logic [3:0] ST_MEM_WR   = 4'd7;
   localparam logic [3:0] ST_ALU_WB   = 4'd8;
   localparam logic [3:0] ST_TRAP     = 4'd9;

   // Everything the controller drives toward the datapath, minus instret
   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       mem_write;
      logic       mdr_write;
      logic       reg_write;
      logic [2:0] imm_ctrl;
      logic [3:0] alu_ctrl;
      logic       alu_in2_ctrl;
      logic       addrsrc_ctrl;
      logic       regwrite_ctrl;
      logic       illegal;
   } ctrl_out_t;

   // True for LW/SW: the only memory encodings the core accepts
   function automatic logic is_word_mem(input logic [6:0] opcode, input logic [2:0] funct3);
      return ((opcode == OP_LOAD) || (opcode == OP_STORE)) && (funct3 == F3_WORD);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the instruction register / datapath and the control FSM.
//   opcode, funct3, funct7_5 : IR fields (driven by the IR side)
//   pc_write .. illegal      : strobes and selects (driven by the controller)
//   instret                  : retired-instruction count
// Modports: master = IR/datapath side, slave = controller.
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if #(
   parameter int INSTRET_W = 32
);
   logic [6:0]           opcode;
   logic [2:0]           funct3;
   logic                 funct7_5;
   logic                 pc_write;
   logic                 ir_write;
   logic                 mem_write;
   logic                 mdr_write;
   logic                 reg_write;
   logic [2:0]           imm_ctrl;
   logic [3:0]           alu_ctrl;
   logic                 alu_in2_ctrl;
   logic                 addrsrc_ctrl;
   logic                 regwrite_ctrl;
   logic                 illegal;
   logic [INSTRET_W-1:0] instret;

   modport master (
      output opcode, funct3, funct7_5,
      input  pc_write, ir_write, mem_write, mdr_write, reg_write,
      input  imm_ctrl, alu_ctrl, alu_in2_ctrl, addrsrc_ctrl, regwrite_ctrl,
      input  illegal, instret
   );

   modport slave (
      input  opcode, funct3, funct7_5,
      output pc_write, ir_write, mem_write, mdr_write, reg_write,
      output imm_ctrl, alu_ctrl, alu_in2_ctrl, addrsrc_ctrl, regwrite_ctrl,
      output illegal, instret
   );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_alu_decoder
// Combinational ALU-operation decode for R-type and I-type ALU instructions.
//   is_itype  in  1 : 1 for OP-IMM, 0 for OP
//   funct3    in  3 : IR[14:12]
//   funct7_5  in  1 : IR[30]
//   alu_ctrl  out 4 : ALU operation code
//   legal     out 1 : encoding is a supported instruction
// -----------------------------------------------------------------------------
module multicycle_ctrl_alu_decoder
   import multicycle_ctrl_pkg::*;
(
   input  logic       is_itype,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [3:0] alu_ctrl,
   output logic       legal
);

   // IR[30] is an opcode-extension bit for R-type, but only a shift-type
   // selector (srai) or a plain immediate bit for I-type.
   always_comb begin
      alu_ctrl = ALU_ADD;
      legal    = 1'b1;
      case (funct3)
         3'b000: begin
            if (!is_itype && funct7_5) begin
               alu_ctrl = ALU_SUB;
            end else begin
               alu_ctrl = ALU_ADD;
            end
         end
         3'b001: begin
            alu_ctrl = ALU_SLL;
            legal    = ~funct7_5;
         end
         3'b010: begin
            alu_ctrl = ALU_SLT;
            legal    = is_itype | ~funct7_5;
         end
         3'b011: begin
            alu_ctrl = ALU_SLTU;
            legal    = is_itype | ~funct7_5;
         end
         3'b100: begin
            alu_ctrl = ALU_XOR;
            legal    = is_itype | ~funct7_5;
         end
         3'b101: begin
            if (funct7_5) begin
               alu_ctrl = ALU_SRA;
            end else begin
               alu_ctrl = ALU_SRL;
            end
         end
         3'b110: begin
            alu_ctrl = ALU_OR;
            legal    = is_itype | ~funct7_5;
         end
         3'b111: begin
            alu_ctrl = ALU_AND;
            legal    = is_itype | ~funct7_5;
         end
         default: begin
            alu_ctrl = ALU_ADD;
            legal    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM of the RV32I multicycle core. Sequences FETCH, DECODE,
// EXECUTE, memory and write-back steps for R-type ALU, I-type ALU, LW and SW,
// traps (or skips) every other encoding, and counts retired instructions.
//   clk  in : rising-edge clock
//   rst  in : synchronous active-high reset; forces every output to 0
//   bus     : multicycle_ctrl_if.slave (IR fields in, strobes/selects out)
// Parameters:
//   TRAP_ON_ILLEGAL : 1 = illegal encoding parks in TRAP, 0 = treated as NOP
//   INSTRET_W       : width of the retired-instruction counter
// -----------------------------------------------------------------------------
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int TRAP_ON_ILLEGAL = 1,
   parameter int INSTRET_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.slave  bus
);

   logic [3:0]           state_r;
   logic [3:0]           next_s;
   logic [3:0]           dec_alu_s;
   logic                 dec_legal_s;
   logic                 is_itype_s;
   logic [2:0]           mem_imm_s;
   logic                 retire_s;
   ctrl_out_t            out_s;
   ctrl_out_t            out_gated_s;
   logic [INSTRET_W-1:0] instret_r;

   assign is_itype_s = (bus.opcode == OP_I);
   assign mem_imm_s  = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
   assign retire_s   = (state_r == ST_ALU_WB) || (state_r == ST_MEM_WB) || (state_r == ST_MEM_WR);

   multicycle_ctrl_alu_decoder u_alu_decoder (
      .is_itype (is_itype_s),
      .funct3   (bus.funct3),
      .funct7_5 (bus.funct7_5),
      .alu_ctrl (dec_alu_s),
      .legal    (dec_legal_s)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_FETCH;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state logic; IR fields are stable from DECODE until the next FETCH
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_FETCH:    next_s = ST_DECODE;
         ST_DECODE: begin
            if ((bus.opcode == OP_R) && dec_legal_s) begin
               next_s = ST_EXEC_R;
            end else if ((bus.opcode == OP_I) && dec_legal_s) begin
               next_s = ST_EXEC_I;
            end else if (is_word_mem(bus.opcode, bus.funct3)) begin
               next_s = ST_MEM_ADDR;
            end else if (TRAP_ON_ILLEGAL != 0) begin
               next_s = ST_TRAP;
            end else begin
               next_s = ST_FETCH;
            end
         end
         ST_EXEC_R:   next_s = ST_ALU_WB;
         ST_EXEC_I:   next_s = ST_ALU_WB;
         ST_ALU_WB:   next_s = ST_FETCH;
         ST_MEM_ADDR: begin
            if (bus.opcode == OP_LOAD) begin
               next_s = ST_MEM_RD;
            end else begin
               next_s = ST_MEM_WR;
            end
         end
         ST_MEM_RD:   next_s = ST_MEM_WB;
         ST_MEM_WB:   next_s = ST_FETCH;
         ST_MEM_WR:   next_s = ST_FETCH;
         ST_TRAP:     next_s = ST_TRAP;
         default:     next_s = ST_FETCH;
      endcase
   end

   // Moore output decode; selects are held from EXEC/MEM_ADDR into the
   // following cycle so the datapath sees a stable ALU result.
   always_comb begin
      out_s = '0;
      case (state_r)
         ST_FETCH: begin
            out_s.pc_write = 1'b1;
            out_s.ir_write = 1'b1;
         end
         ST_DECODE: begin
            out_s = '0;
         end
         ST_EXEC_R: begin
            out_s.alu_ctrl = dec_alu_s;
         end
         ST_EXEC_I: begin
            out_s.alu_ctrl     = dec_alu_s;
            out_s.alu_in2_ctrl = 1'b1;
            out_s.imm_ctrl     = IMM_I;
         end
         ST_ALU_WB: begin
            out_s.reg_write = 1'b1;
            out_s.alu_ctrl  = dec_alu_s;
            if (is_itype_s) begin
               out_s.alu_in2_ctrl = 1'b1;
               out_s.imm_ctrl     = IMM_I;
            end else begin
               out_s.alu_in2_ctrl = 1'b0;
               out_s.imm_ctrl     = IMM_I;
            end
         end
         ST_MEM_ADDR: begin
            out_s.alu_ctrl     = ALU_ADD;
            out_s.alu_in2_ctrl = 1'b1;
            out_s.imm_ctrl     = mem_imm_s;
         end
         ST_MEM_RD: begin
            out_s.alu_ctrl     = ALU_ADD;
            out_s.alu_in2_ctrl = 1'b1;
            out_s.imm_ctrl     = mem_imm_s;
            out_s.addrsrc_ctrl = 1'b1;
            out_s.mdr_write    = 1'b1;
         end
         ST_MEM_WB: begin
            out_s.reg_write     = 1'b1;
            out_s.regwrite_ctrl = 1'b1;
         end
         ST_MEM_WR: begin
            out_s.alu_ctrl     = ALU_ADD;
            out_s.alu_in2_ctrl = 1'b1;
            out_s.imm_ctrl     = mem_imm_s;
            out_s.addrsrc_ctrl = 1'b1;
            out_s.mem_write    = 1'b1;
         end
         ST_TRAP: begin
            out_s.illegal = 1'b1;
         end
         default: begin
            out_s = '0;
         end
      endcase
   end

   // Retired-instruction counter; TRAP and NOP-skipped encodings never retire
   always_ff @(posedge clk) begin
      if (rst) begin
         instret_r <= '0;
      end else if (retire_s) begin
         instret_r <= instret_r + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end else begin
         instret_r <= instret_r;
      end
   end

   // rst blanks the outputs immediately so a mid-instruction reset never
   // leaks a partial strobe in the cycle it is asserted.
   assign out_gated_s       = rst ? '0 : out_s;
   assign bus.pc_write      = out_gated_s.pc_write;
   assign bus.ir_write      = out_gated_s.ir_write;
   assign bus.mem_write     = out_gated_s.mem_write;
   assign bus.mdr_write     = out_gated_s.mdr_write;
   assign bus.reg_write     = out_gated_s.reg_write;
   assign bus.imm_ctrl      = out_gated_s.imm_ctrl;
   assign bus.alu_ctrl      = out_gated_s.alu_ctrl;
   assign bus.alu_in2_ctrl  = out_gated_s.alu_in2_ctrl;
   assign bus.addrsrc_ctrl  = out_gated_s.addrsrc_ctrl;
   assign bus.regwrite_ctrl = out_gated_s.regwrite_ctrl;
   assign bus.illegal       = out_gated_s.illegal;
   assign bus.instret       = rst ? '0 : instret_r;

endmodule
